// File: rtl/phase_gen_if.sv
// rtl/phase_gen_if.sv - tuning-word update channel between a controller and phase_gen
interface phase_gen_if #(
  parameter int PHASE_W = 21,
  parameter int FRAC_W  = 11
) ();
  localparam int ACC_W = PHASE_W + FRAC_W;

  logic [ACC_W-1:0]   ftw_data;
  logic [PHASE_W-1:0] poff_data;
  logic               upd_mode;
  logic               ftw_valid;
  logic               ftw_ready;

  modport master (
    output ftw_data,
    output poff_data,
    output upd_mode,
    output ftw_valid,
    input  ftw_ready
  );

  modport slave (
    input  ftw_data,
    input  poff_data,
    input  upd_mode,
    input  ftw_valid,
    output ftw_ready
  );
endinterface

// File: rtl/phase_gen.sv
// rtl/phase_gen.sv - NCO phase accumulator with immediate or wrap-deferred tuning updates
module phase_gen #(
  parameter int PHASE_W = 21,
  parameter int FRAC_W  = 11
) (
  input  logic               clk,
  input  logic               rst,
  phase_gen_if.slave         upd,
  input  logic               sample_en,
  input  logic               sync_clr,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               wrap,
  output logic [1:0]         quadrant
);
  localparam int ACC_W = PHASE_W + FRAC_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   ftw_q, ftw_d;
  logic [PHASE_W-1:0] poff_q, poff_d;
  logic [ACC_W-1:0]   shd_ftw_q, shd_ftw_d;
  logic [PHASE_W-1:0] shd_poff_q, shd_poff_d;
  logic               carry_q, carry_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phase_valid_q, phase_valid_d;
  logic               wrap_q, wrap_d;

  logic               handshake;
  logic               step;
  logic [ACC_W:0]     sum;

  assign upd.ftw_ready = (state_q != ST_PEND);
  assign handshake     = upd.ftw_valid && upd.ftw_ready;
  assign step          = (state_q != ST_IDLE) && sample_en && !sync_clr;
  assign sum           = {1'b0, acc_q} + {1'b0, ftw_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      ftw_q         <= '0;
      poff_q        <= '0;
      shd_ftw_q     <= '0;
      shd_poff_q    <= '0;
      carry_q       <= 1'b0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      ftw_q         <= ftw_d;
      poff_q        <= poff_d;
      shd_ftw_q     <= shd_ftw_d;
      shd_poff_q    <= shd_poff_d;
      carry_q       <= carry_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    ftw_d         = ftw_q;
    poff_d        = poff_q;
    shd_ftw_d     = shd_ftw_q;
    shd_poff_d    = shd_poff_q;
    carry_d       = carry_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    wrap_d        = 1'b0;

    // Output is the pre-increment accumulator, so the step always uses the current ftw/poff
    if (sync_clr) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (step) begin
      phase_d       = acc_q[ACC_W-1:FRAC_W] + poff_q;
      acc_d         = sum[ACC_W-1:0];
      carry_d       = sum[ACC_W];
      wrap_d        = carry_q;
      phase_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          ftw_d   = upd.ftw_data;
          poff_d  = upd.poff_data;
          acc_d   = '0;
          carry_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (handshake) begin
          if (upd.upd_mode) begin
            shd_ftw_d  = upd.ftw_data;
            shd_poff_d = upd.poff_data;
            state_d    = ST_PEND;
          end else begin
            ftw_d  = upd.ftw_data;
            poff_d = upd.poff_data;
          end
        end
      end
      ST_PEND: begin
        // The carrying step lands the accumulator on the cycle boundary; swap words there
        if (step && sum[ACC_W]) begin
          ftw_d   = shd_ftw_q;
          poff_d  = shd_poff_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;
  assign quadrant    = phase_q[PHASE_W-1:PHASE_W-2];
endmodule

// File: tb/tb_phase_gen.sv
// tb/tb_phase_gen.sv - scoreboard bench for phase_gen
module tb_phase_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic        sync_clr;
  logic [20:0] phase;
  logic        phase_valid;
  logic        wrap;
  logic [1:0]  quadrant;

  typedef struct {
    logic [20:0] ph;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  phase_gen_if u_if ();

  phase_gen u_dut (
    .clk         (clk),
    .rst         (rst),
    .upd         (u_if.slave),
    .sample_en   (sample_en),
    .sync_clr    (sync_clr),
    .phase       (phase),
    .phase_valid (phase_valid),
    .wrap        (wrap),
    .quadrant    (quadrant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && phase_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_phase_valid", {11'd0, phase}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("phase", {11'd0, phase}, {11'd0, e.ph});
        chk("wrap", {31'd0, wrap}, {31'd0, e.wr});
        chk("quadrant", {30'd0, quadrant}, {30'd0, e.ph[20:19]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] ftw, input logic [20:0] poff, input logic mode);
    chk("ftw_ready_before_load", {31'd0, u_if.ftw_ready}, 32'd1);
    u_if.ftw_data  = ftw;
    u_if.poff_data = poff;
    u_if.upd_mode  = mode;
    u_if.ftw_valid = 1'b1;
    tick();
    u_if.ftw_valid = 1'b0;
  endtask

  task automatic samp(input logic [20:0] ph, input logic wr);
    exp_t e;
    e.ph = ph;
    e.wr = wr;
    sb.push_back(e);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    sample_en      = 1'b0;
    sync_clr       = 1'b0;
    u_if.ftw_data  = '0;
    u_if.poff_data = '0;
    u_if.upd_mode  = 1'b0;
    u_if.ftw_valid = 1'b0;
    #1;
    chk("rst_ftw_ready", {31'd0, u_if.ftw_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_phase", {11'd0, phase}, 32'd0);
    chk("rst_valid", {31'd0, phase_valid}, 32'd0);
    chk("rst_wrap", {31'd0, wrap}, 32'd0);
    chk("rst_quadrant", {30'd0, quadrant}, 32'd0);

    // slow ramp with offset in quadrant 2
    load(32'h0000_0800, 21'h100000, 1'b0);
    samp(21'h100000, 1'b0);
    samp(21'h100001, 1'b0);
    samp(21'h100002, 1'b0);
    samp(21'h100003, 1'b0);
    do_reset();

    // quarter-cycle steps through a wrap
    load(32'h4000_0000, 21'h0, 1'b0);
    samp(21'h000000, 1'b0);
    samp(21'h080000, 1'b0);
    samp(21'h100000, 1'b0);
    samp(21'h180000, 1'b0);
    samp(21'h000000, 1'b1);
    samp(21'h080000, 1'b0);
    do_reset();

    // deferred update applied at the wrap
    load(32'h4000_0000, 21'h0, 1'b0);
    samp(21'h000000, 1'b0);
    load(32'h2000_0000, 21'h0, 1'b1);
    chk("pend_ready_0", {31'd0, u_if.ftw_ready}, 32'd0);
    samp(21'h080000, 1'b0);
    chk("pend_ready_1", {31'd0, u_if.ftw_ready}, 32'd0);
    samp(21'h100000, 1'b0);
    chk("pend_ready_2", {31'd0, u_if.ftw_ready}, 32'd0);
    samp(21'h180000, 1'b0);
    chk("apply_ready", {31'd0, u_if.ftw_ready}, 32'd1);
    samp(21'h000000, 1'b1);
    samp(21'h040000, 1'b0);
    do_reset();

    // immediate update keeps phase continuous
    load(32'h4000_0000, 21'h0, 1'b0);
    samp(21'h000000, 1'b0);
    samp(21'h080000, 1'b0);
    load(32'h0000_1000, 21'h0, 1'b0);
    samp(21'h100000, 1'b0);
    samp(21'h100002, 1'b0);
    do_reset();

    // sync_clr suppresses the sample and clears the pending carry
    load(32'h4000_0000, 21'h012345, 1'b0);
    samp(21'h012345, 1'b0);
    samp(21'h092345, 1'b0);
    samp(21'h112345, 1'b0);
    samp(21'h192345, 1'b0);
    sync_clr  = 1'b1;
    sample_en = 1'b1;
    tick();
    sync_clr  = 1'b0;
    sample_en = 1'b0;
    chk("clr_no_valid", {31'd0, phase_valid}, 32'd0);
    chk("clr_phase_hold", {11'd0, phase}, 32'h192345);
    samp(21'h012345, 1'b0);
    load(32'h0000_1000, 21'h0, 1'b1);
    chk("pend_before_rst", {31'd0, u_if.ftw_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_phase", {11'd0, phase}, 32'd0);
    chk("arst_valid", {31'd0, phase_valid}, 32'd0);
    chk("arst_wrap", {31'd0, wrap}, 32'd0);
    chk("arst_quadrant", {30'd0, quadrant}, 32'd0);
    chk("arst_ready", {31'd0, u_if.ftw_ready}, 32'd1);
    tick();
    rst = 1'b0;

    // IDLE ignores sample_en
    sample_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", {31'd0, phase_valid}, 32'd0);
      chk("idle_phase", {11'd0, phase}, 32'd0);
    end
    sample_en = 1'b0;

    // after reset the deferred request is treated as an IDLE load
    load(32'h4000_0000, 21'h0, 1'b1);
    chk("idle_load_ready", {31'd0, u_if.ftw_ready}, 32'd1);
    samp(21'h000000, 1'b0);
    samp(21'h080000, 1'b0);
    tick();
    tick();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
